// File: rtl/sccu_ifetch.sv
// sccu_ifetch: multicycle instruction fetch for the single-cycle control unit.
// Three-state IDLE/FETCH/EXEC sequencer with an instruction register and a next-PC mux.
module sccu_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  pcsource,
  input  logic [31:0] rs_data,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        inst_valid,
  output logic [31:0] icount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] ir;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign op   = ir[31:26];
  assign rs   = ir[25:21];
  assign rt   = ir[20:16];
  assign rd   = ir[15:11];
  assign sa   = ir[10:6];
  assign func = ir[5:0];
  assign imm  = ir[15:0];

  assign pc4       = pc + 32'd4;
  assign imem_addr = pc;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (run) state_nx = FETCH;
      FETCH:   if (imem_ack) state_nx = EXEC;
      EXEC:    state_nx = run ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    unique case (state)
      FETCH:   imem_req   = 1'b1;
      EXEC:    inst_valid = 1'b1;
      default: ;
    endcase
  end

  // next-PC select; only consumed on the EXEC closing edge
  always_comb begin
    br_off  = {{14{imm[15]}}, imm, 2'b00};
    next_pc = pc4;
    unique case (pcsource)
      2'b00: next_pc = pc4;
      2'b01: next_pc = pc4 + br_off;
      2'b10: next_pc = rs_data & 32'hFFFF_FFFC;
      2'b11: next_pc = {pc4[31:28], ir[25:0], 2'b00};
      default: next_pc = pc4;
    endcase
  end

  // pc / ir / retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= 32'd0;
      icount <= 32'd0;
    end else begin
      if (state == FETCH && imem_ack)
        ir <= imem_rdata;
      if (state == EXEC) begin
        pc     <= next_pc;
        icount <= icount + 32'd1;
      end
    end
  end

endmodule
